// File: rtl/fir_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fir_adder_tree_pipe
// Description : Pipelined signed adder tree reducing N_IN lanes to one sum,
//               followed by a registered round/shift/saturate-or-wrap stage.
//               A valid bit travels alongside the data and one global advance
//               enable gives ready/valid backpressure at the output.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_adder_tree_pipe #(
  parameter int N_IN      = 16,
  parameter int IN_W      = 28,
  parameter int OUT_W     = 32,
  parameter int REG_EVERY = 1,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int SAT       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     sum_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat_flag
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int SUM_W  = IN_W + LEVELS;
  localparam int N_PAD  = 1 << LEVELS;
  // Wide enough to hold the shifted sum and both clamp limits without loss.
  localparam int EXT_W  = ((SUM_W + 1 > OUT_W) ? SUM_W + 1 : OUT_W) + 1;

  localparam int c_rnd_sh = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [SUM_W:0] c_rnd_add =
      (ROUND != 0 && SHIFT > 0) ? ((SUM_W + 1)'(1) << c_rnd_sh) : {(SUM_W + 1){1'b0}};
  localparam logic signed [EXT_W-1:0] c_sat_max = {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] c_sat_min = {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic                   adv;
  logic [N_PAD*SUM_W-1:0] w_leaf;

  // Leaves: node i holds lane i sign-extended to SUM_W; lane 0 sits in the
  // input MSBs. Padding leaves are zero so an odd node simply passes through.
  for (genvar i = 0; i < N_PAD; i++) begin : g_leaf
    if (i < N_IN) begin : g_real
      assign w_leaf[i*SUM_W +: SUM_W] =
          {{LEVELS{in_data[(N_IN-1-i)*IN_W + IN_W - 1]}}, in_data[(N_IN-1-i)*IN_W +: IN_W]};
    end else begin : g_pad
      assign w_leaf[i*SUM_W +: SUM_W] = '0;
    end
  end

  // One generate scope per adder level; each halves the node count.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int IN_N  = N_PAD >> (k - 1);
    localparam int OUT_N = N_PAD >> k;

    logic [IN_N*SUM_W-1:0]  w_in;
    logic [OUT_N*SUM_W-1:0] w_sum;
    logic [OUT_N*SUM_W-1:0] w_out;
    logic                   w_vin;
    logic                   w_vout;

    if (k == 1) begin : g_first
      assign w_in  = w_leaf;
      assign w_vin = in_valid;
    end else begin : g_next
      assign w_in  = g_lvl[k-1].w_out;
      assign w_vin = g_lvl[k-1].w_vout;
    end

    // Pairwise adds in index order; SUM_W is wide enough that nothing overflows.
    always_comb begin
      w_sum = '0;
      for (int j = 0; j < OUT_N; j++) begin
        w_sum[j*SUM_W +: SUM_W] = w_in[(2*j)*SUM_W +: SUM_W] + w_in[(2*j+1)*SUM_W +: SUM_W];
      end
    end

    if (((k % REG_EVERY) == 0) || (k == LEVELS)) begin : g_reg
      logic [OUT_N*SUM_W-1:0] data_q;
      logic                   vld_q;

      // Pipeline register for this level; holds everything while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else if (adv) begin
          data_q <= w_sum;
          vld_q  <= w_vin;
        end
      end

      assign w_out  = data_q;
      assign w_vout = vld_q;
    end else begin : g_comb
      assign w_out  = w_sum;
      assign w_vout = w_vin;
    end
  end

  logic [SUM_W-1:0]        w_root;
  logic                    w_root_vld;
  logic signed [SUM_W:0]   w_rnd;
  logic signed [SUM_W:0]   w_shf;
  logic signed [EXT_W-1:0] w_ext;
  logic [OUT_W-1:0]        sum_d;
  logic [OUT_W-1:0]        sum_q;
  logic                    sat_d;
  logic                    sat_q;
  logic                    vld_q;

  assign w_root     = g_lvl[LEVELS].w_out;
  assign w_root_vld = g_lvl[LEVELS].w_vout;

  // Rounding add one bit wider than the sum so the half-LSB can never wrap.
  assign w_rnd = $signed({w_root[SUM_W-1], w_root}) + $signed(c_rnd_add);
  assign w_shf = w_rnd >>> SHIFT;
  assign w_ext = {{(EXT_W - SUM_W - 1){w_shf[SUM_W]}}, w_shf};

  // Output formatting: clamp with flag when saturating, otherwise keep low bits.
  always_comb begin
    sum_d = w_ext[OUT_W-1:0];
    sat_d = 1'b0;
    if (SAT != 0) begin
      if (w_ext > c_sat_max) begin
        sum_d = c_sat_max[OUT_W-1:0];
        sat_d = 1'b1;
      end else if (w_ext < c_sat_min) begin
        sum_d = c_sat_min[OUT_W-1:0];
        sat_d = 1'b1;
      end
    end
  end

  // Output register; contents stay put until downstream takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      sat_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (adv) begin
      sum_q <= sum_d;
      sat_q <= sat_d;
      vld_q <= w_root_vld;
    end
  end

  // The whole pipe moves only when the output slot is empty or being drained.
  assign adv       = out_ready | ~vld_q;
  assign in_ready  = adv;
  assign sum_out   = sum_q;
  assign sat_flag  = sat_q;
  assign out_valid = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_adder_tree_pipe
// Description : Directed bench for fir_adder_tree_pipe using three parameter
//               sets (default, rounding/saturating, odd lane count).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_adder_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic [16*28-1:0] d0_in_data;
  logic             d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready, d0_sat;
  logic [31:0]      d0_sum;
  // N_IN=4, IN_W=16, OUT_W=16, SHIFT=1, ROUND=1, SAT=1
  logic [4*16-1:0]  d1_in_data;
  logic             d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_sat;
  logic [15:0]      d1_sum;
  // N_IN=5, IN_W=8, REG_EVERY=2, OUT_W=11
  logic [5*8-1:0]   d2_in_data;
  logic             d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_sat;
  logic [10:0]      d2_sum;

  fir_adder_tree_pipe u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sum_out(d0_sum), .out_valid(d0_out_valid),
    .out_ready(d0_out_ready), .sat_flag(d0_sat));

  fir_adder_tree_pipe #(.N_IN(4), .IN_W(16), .OUT_W(16), .REG_EVERY(1),
                        .SHIFT(1), .ROUND(1), .SAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sum_out(d1_sum), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .sat_flag(d1_sat));

  fir_adder_tree_pipe #(.N_IN(5), .IN_W(8), .OUT_W(11), .REG_EVERY(2),
                        .SHIFT(0), .ROUND(0), .SAT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .sum_out(d2_sum), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .sat_flag(d2_sat));

  typedef struct {
    int sel;
    int lane [16];
    int exp_sum;
    bit exp_sat;
    int exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input int fill, input int es, input bit sat, input int lat);
    vec_t v;
    v.sel = sel;
    for (int i = 0; i < 16; i++) v.lane[i] = fill;
    v.exp_sum = es;
    v.exp_sat = sat;
    v.exp_lat = lat;
    return v;
  endfunction

  function automatic bit get_vld(input int sel);
    case (sel)
      0: return d0_out_valid;
      1: return d1_out_valid;
      default: return d2_out_valid;
    endcase
  endfunction

  function automatic bit get_rdy(input int sel);
    case (sel)
      0: return d0_in_ready;
      1: return d1_in_ready;
      default: return d2_in_ready;
    endcase
  endfunction

  function automatic bit get_sat(input int sel);
    case (sel)
      0: return d0_sat;
      1: return d1_sat;
      default: return d2_sat;
    endcase
  endfunction

  function automatic int get_sum(input int sel);
    case (sel)
      0: return int'($signed(d0_sum));
      1: return int'($signed(d1_sum));
      default: return int'($signed(d2_sum));
    endcase
  endfunction

  task automatic drive(input vec_t v, input bit vld);
    case (v.sel)
      0: begin
        for (int i = 0; i < 16; i++) d0_in_data[(15-i)*28 +: 28] = 28'(v.lane[i]);
        d0_in_valid = vld;
      end
      1: begin
        for (int i = 0; i < 4; i++) d1_in_data[(3-i)*16 +: 16] = 16'(v.lane[i]);
        d1_in_valid = vld;
      end
      default: begin
        for (int i = 0; i < 5; i++) d2_in_data[(4-i)*8 +: 8] = 8'(v.lane[i]);
        d2_in_valid = vld;
      end
    endcase
  endtask

  // Send one beat, time its arrival and check value, flag and single-cycle valid.
  task automatic run_vec(input vec_t v, input int idx);
    int c;
    bit seen;
    @(negedge clk);
    drive(v, 1'b1);
    #1 check($sformatf("v%0d in_ready", idx), get_rdy(v.sel), 1);
    @(posedge clk);
    @(negedge clk);
    drive(v, 1'b0);
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 20) begin
      if (get_vld(v.sel)) seen = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check($sformatf("v%0d latency", idx), seen ? c : -1, v.exp_lat);
    if (seen) begin
      check($sformatf("v%0d sum_out", idx), get_sum(v.sel), v.exp_sum);
      check($sformatf("v%0d sat_flag", idx), get_sat(v.sel), v.exp_sat);
      @(negedge clk);
      check($sformatf("v%0d out_valid one cycle", idx), get_vld(v.sel), 0);
    end
  endtask

  task automatic fill_d0(input int val);
    for (int i = 0; i < 16; i++) d0_in_data[(15-i)*28 +: 28] = 28'(val);
  endtask

  // Back-to-back ramp with a three-cycle output stall in the middle.
  task automatic run_stream();
    localparam int NB = 12;
    int k = 0;
    int expk = 0;
    int cyc = 0;
    int extra = 0;
    bit acc;
    logic [31:0] held = '0;
    while (expk < NB && cyc < 100) begin
      @(negedge clk);
      d0_out_ready = !(cyc >= 8 && cyc <= 10);
      if (k < NB) begin
        fill_d0(k);
        d0_in_valid = 1'b1;
      end else begin
        d0_in_valid = 1'b0;
      end
      #1;
      if (cyc >= 8 && cyc <= 10) begin
        check($sformatf("stall c%0d in_ready", cyc), d0_in_ready, 0);
        check($sformatf("stall c%0d out_valid", cyc), d0_out_valid, 1);
        if (cyc == 8) held = d0_sum;
        else check($sformatf("stall c%0d sum stable", cyc), d0_sum, held);
      end
      if (d0_out_valid && d0_out_ready) begin
        check($sformatf("stream beat %0d", expk), int'($signed(d0_sum)), 16 * expk);
        expk++;
      end
      acc = d0_in_valid && d0_in_ready;
      @(posedge clk);
      if (acc) k++;
      cyc++;
    end
    check("stream beats out", expk, NB);
    d0_in_valid = 1'b0;
    d0_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d0_out_valid) extra++;
    end
    check("stream no duplicate", extra, 0);
  endtask

  // Reset while beats are in flight and while a result is stalled at the output.
  task automatic run_reset();
    int seen;
    vec_t v;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      fill_d0(100 + b);
      d0_in_valid = 1'b1;
    end
    @(negedge clk);
    d0_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst A out_valid", d0_out_valid, 0);
    check("rst A in_ready", d0_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d0_out_valid) seen++;
    end
    check("rst A flushed beats", seen, 0);

    // Stall a result at the output, then reset asynchronously between edges.
    d0_out_ready = 1'b0;
    fill_d0(9);
    d0_in_valid = 1'b1;
    @(negedge clk);
    d0_in_valid = 1'b0;
    for (int i = 0; i < 10 && !d0_out_valid; i++) @(negedge clk);
    check("rst B stalled out_valid", d0_out_valid, 1);
    check("rst B stalled sum", int'($signed(d0_sum)), 144);
    #2 rst_n = 1'b0;
    #1;
    check("rst B out_valid drop", d0_out_valid, 0);
    check("rst B sum_out cleared", d0_sum, 0);
    check("rst B in_ready", d0_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    d0_out_ready = 1'b1;
    v = mk(0, 7, 112, 1'b0, 5);
    run_vec(v, 99);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    d0_in_data = '0; d1_in_data = '0; d2_in_data = '0;
    d0_in_valid = 1'b0; d1_in_valid = 1'b0; d2_in_valid = 1'b0;
    d0_out_ready = 1'b1; d1_out_ready = 1'b1; d2_out_ready = 1'b1;

    // Default: LAT=5, wrap, full-precision sums
    vecs.push_back(mk(0, 1, 16, 1'b0, 5));
    vecs.push_back(mk(0, -(1 << 27), -2147483647 - 1, 1'b0, 5));
    vecs.push_back(mk(0, (1 << 27) - 1, 2147483632, 1'b0, 5));
    v = mk(0, 0, -8, 1'b0, 5);
    for (int i = 0; i < 16; i++) v.lane[i] = i - 8;
    vecs.push_back(v);
    // Round half up, shift 1, saturate to 16 bits: LAT=3
    v = mk(1, 0, 2, 1'b0, 3);      v.lane[0] = 3;  vecs.push_back(v);
    v = mk(1, 0, -1, 1'b0, 3);     v.lane[0] = -3; vecs.push_back(v);
    v = mk(1, 0, 1, 1'b0, 3);      v.lane[0] = 1;  vecs.push_back(v);
    v = mk(1, 0, 0, 1'b0, 3);      v.lane[0] = -1; vecs.push_back(v);
    vecs.push_back(mk(1, 32767, 32767, 1'b1, 3));
    vecs.push_back(mk(1, -32768, -32768, 1'b1, 3));
    v = mk(1, 0, 32767, 1'b0, 3);  v.lane[0] = 32767;  v.lane[1] = 32767;  vecs.push_back(v);
    v = mk(1, 0, -32768, 1'b0, 3); v.lane[0] = -32768; v.lane[1] = -32768; vecs.push_back(v);
    // Five lanes, register every two levels: LAT=3
    v = mk(2, 0, 15, 1'b0, 3);
    for (int i = 0; i < 5; i++) v.lane[i] = i + 1;
    vecs.push_back(v);
    vecs.push_back(mk(2, -128, -640, 1'b0, 3));
    vecs.push_back(mk(2, 127, 635, 1'b0, 3));

    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset dut%0d out_valid", s), get_vld(s), 0);
      check($sformatf("reset dut%0d sum_out", s), get_sum(s), 0);
      check($sformatf("reset dut%0d sat_flag", s), get_sat(s), 0);
      check($sformatf("reset dut%0d in_ready", s), get_rdy(s), 1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
    run_stream();
    run_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
